// File: rtl/anita4_trig_pkg.sv
// Shared types and helpers for the ANITA-4 phi-sector coincidence trigger.
package anita4_trig_pkg;

  localparam int ANITA4_NUM_PHI = 16;
  localparam int ANITA4_NUM_POL = 2;

  // Widest window the popcount helper can count; windows are zero-extended into it.
  localparam int POPCNT_MAX_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } trig_state_e;

  // Number of set bits in v; callers place a WIN-wide window in the low bits.
  function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCNT_MAX_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/anita4_window_coinc.sv
// One polarisation's M-of-WIN windowed coincidence with wrap-around.
// Window i covers sectors i .. i+WIN-1 modulo NUM_PHI; output is registered.
module anita4_window_coinc
  import anita4_trig_pkg::*;
#(
  parameter int NUM_PHI = ANITA4_NUM_PHI,
  parameter int WIN     = 2,
  parameter int TH_W    = $clog2(WIN + 1)
) (
  input  logic               clk250_i,
  input  logic               rst_n_i,
  input  logic [NUM_PHI-1:0] hq_i,
  input  logic [TH_W-1:0]    thresh_i,
  output logic [NUM_PHI-1:0] coinc_o
);

  logic [NUM_PHI-1:0]      coinc_d;
  logic [NUM_PHI-1:0]      coinc_q;
  logic [POPCNT_MAX_W-1:0] win_v;
  int unsigned             thr_eff;

  // Count hits in each wrapped window and compare against the threshold (0 acts as 1).
  always_comb begin
    coinc_d = '0;
    win_v   = '0;
    thr_eff = (thresh_i == '0) ? 32'd1 : 32'(thresh_i);
    for (int i = 0; i < NUM_PHI; i++) begin
      win_v = '0;
      for (int j = 0; j < WIN; j++) begin
        win_v[j] = hq_i[(i + j) % NUM_PHI];
      end
      coinc_d[i] = (popcount(win_v) >= thr_eff);
    end
  end

  // Stage 2 boundary: register the coincidence bits.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      coinc_q <= '0;
    end else begin
      coinc_q <= coinc_d;
    end
  end

  assign coinc_o = coinc_q;

endmodule

// File: rtl/anita4_coinc_trigger.sv
// ANITA-4 TURF phi-sector coincidence trigger: masking, windowed coincidence,
// trigger FSM with holdoff and a valid/ready pattern hand-off.
// Optional feature macro: ANITA4_COINC_DEADTIME_EN adds clr_i / dead_o deadtime counter.
module anita4_coinc_trigger
  import anita4_trig_pkg::*;
#(
  parameter int NUM_PHI = ANITA4_NUM_PHI,
  parameter int NUM_POL = ANITA4_NUM_POL,
  parameter int WIN     = 2,
  parameter int HOLD_W  = 8
) (
  input  logic                       clk250_i,
  input  logic                       rst_n_i,
  input  logic [NUM_POL*NUM_PHI-1:0] phi_i,
  input  logic [NUM_POL*NUM_PHI-1:0] mask_i,
  input  logic [$clog2(WIN+1)-1:0]   thresh_i,
  input  logic [HOLD_W-1:0]          holdoff_i,
`ifdef ANITA4_COINC_DEADTIME_EN
  input  logic                       clr_i,
  output logic [31:0]                dead_o,
`endif
  output logic                       trig_o,
  output logic [NUM_POL-1:0]         trig_pol_o,
  output logic [NUM_POL*NUM_PHI-1:0] scal_o,
  output logic [NUM_POL*NUM_PHI-1:0] pat_o,
  output logic                       pat_valid_o,
  input  logic                       pat_ready_i
);

  localparam int NB = NUM_POL * NUM_PHI;

  logic [NB-1:0]      phi_p0_q;
  logic [NB-1:0]      hq_p1_q;
  logic [NB-1:0]      coinc_p2_q;
  logic [NUM_POL-1:0] any_p2;

  trig_state_e        state_q, state_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic               trig_q, trig_d;
  logic [NUM_POL-1:0] pol_q, pol_d;
  logic [NB-1:0]      pat_q, pat_d;
  logic               pat_valid_q, pat_valid_d;
  logic               hs;

  // Stage 0/1 boundaries: capture raw hits, then apply the sector mask.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phi_p0_q <= '0;
      hq_p1_q  <= '0;
    end else begin
      phi_p0_q <= phi_i;
      hq_p1_q  <= phi_p0_q & ~mask_i;
    end
  end

  // Stage 2: one windowed coincidence block per polarisation.
  for (genvar p = 0; p < NUM_POL; p++) begin : g_pol
    anita4_window_coinc #(
      .NUM_PHI (NUM_PHI),
      .WIN     (WIN),
      .TH_W    ($clog2(WIN + 1))
    ) u_win (
      .clk250_i (clk250_i),
      .rst_n_i  (rst_n_i),
      .hq_i     (hq_p1_q[p*NUM_PHI +: NUM_PHI]),
      .thresh_i (thresh_i),
      .coinc_o  (coinc_p2_q[p*NUM_PHI +: NUM_PHI])
    );
  end

  // Stage 3: per-polarisation OR of the coincidence bits.
  always_comb begin
    any_p2 = '0;
    for (int p = 0; p < NUM_POL; p++) begin
      any_p2[p] = |coinc_p2_q[p*NUM_PHI +: NUM_PHI];
    end
  end

  // Trigger FSM next state: a handshake in this cycle counts as the pattern being consumed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trig_d      = 1'b0;
    pol_d       = '0;
    pat_d       = pat_q;
    pat_valid_d = pat_valid_q;
    hs          = pat_valid_q & pat_ready_i;
    if (hs) begin
      pat_valid_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (|any_p2) begin
          trig_d      = 1'b1;
          pol_d       = any_p2;
          pat_d       = coinc_p2_q;
          pat_valid_d = 1'b1;
          cnt_d       = (holdoff_i == '0) ? HOLD_W'(1) : holdoff_i;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= HOLD_W'(1)) begin
          state_d = (!pat_valid_q || hs) ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Trigger FSM state, holdoff counter, trigger outputs and pattern latch.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      trig_q      <= 1'b0;
      pol_q       <= '0;
      pat_q       <= '0;
      pat_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trig_q      <= trig_d;
      pol_q       <= pol_d;
      pat_q       <= pat_d;
      pat_valid_q <= pat_valid_d;
    end
  end

`ifdef ANITA4_COINC_DEADTIME_EN
  logic [31:0] dead_q;

  // Deadtime: clocks spent outside IDLE, saturating; clear wins over increment.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dead_q <= '0;
    end else if (clr_i) begin
      dead_q <= '0;
    end else if ((state_q != ST_IDLE) && (dead_q != 32'hFFFF_FFFF)) begin
      dead_q <= dead_q + 32'd1;
    end
  end

  assign dead_o = dead_q;
`endif

  assign trig_o      = trig_q;
  assign trig_pol_o  = pol_q;
  assign scal_o      = coinc_p2_q;
  assign pat_o       = pat_q;
  assign pat_valid_o = pat_valid_q;

endmodule
